// File: rtl/fu_writeback_arbiter_pkg.sv
// Shared CPU definitions used by the writeback arbiter: commit bus layout,
// functional-unit identifiers and default sizing.
package fu_writeback_arbiter_pkg;

  localparam int WB_NUM_FU    = 6;
  localparam int WB_NUM_PORTS = 2;

  typedef logic [$clog2(WB_NUM_FU)-1:0] fu_id_t;

  localparam fu_id_t FU_ALU1   = 3'd0;
  localparam fu_id_t FU_ALU2   = 3'd1;
  localparam fu_id_t FU_BRU    = 3'd2;
  localparam fu_id_t FU_MULDIV = 3'd3;
  localparam fu_id_t FU_LSU    = 3'd4;
  localparam fu_id_t FU_CSR    = 3'd5;

  typedef struct packed {
    logic [7:0]  rob_tag;
    logic [4:0]  rd;
    logic        wen;
    logic        exc;
    logic [4:0]  exc_code;
    logic [31:0] pc;
    logic [63:0] wdata;
    logic [11:0] rsvd;
  } execute_to_commit_bus_t;

  localparam int WB_PAYLOAD_W = $bits(execute_to_commit_bus_t);

endpackage

// File: rtl/fu_writeback_arbiter_wb_port_allocator.sv
// Combinational grant network: maps held FU results onto commit ports,
// pairs taking ports 0 and 1 atomically, singles filling lowest port first.
import fu_writeback_arbiter_pkg::*;

module wb_port_allocator #(
  parameter int NUM_FU    = WB_NUM_FU,
  parameter int NUM_PORTS = WB_NUM_PORTS,
  localparam int ID_W     = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]                 i_slot_v,
  input  logic [NUM_FU-1:0]                 i_slot_pair,
  input  logic [ID_W-1:0]                   i_rr_ptr,
  output logic [NUM_PORTS-1:0][NUM_FU-1:0]  o_port_sel,
  output logic [NUM_FU-1:0]                 o_granted
);

  // NOTE: blocking assignments in always_comb; every output and local gets a
  // default before the loop so no path leaves a value held (no latch).
  always_comb begin
    int next_port;
    int idx;
    o_port_sel = '0;
    o_granted  = '0;
    next_port  = 0;
    idx        = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(i_rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (i_slot_v[idx]) begin
        if (i_slot_pair[idx]) begin
          // A pair needs both low ports untouched; otherwise it sits this cycle out.
          if (next_port == 0 && NUM_PORTS >= 2) begin
            o_port_sel[0][idx] = 1'b1;
            o_port_sel[1][idx] = 1'b1;
            o_granted[idx]     = 1'b1;
            next_port          = 2;
          end
        end else if (next_port < NUM_PORTS) begin
          o_port_sel[next_port][idx] = 1'b1;
          o_granted[idx]             = 1'b1;
          next_port                  = next_port + 1;
        end
      end
    end
  end

endmodule

// File: rtl/fu_writeback_arbiter.sv
// Writeback arbiter: one holding slot per FU, up to NUM_PORTS grants per cycle.
// Define WB_ARB_RR_EN for round-robin priority; default is fixed (FU 0 highest).
import fu_writeback_arbiter_pkg::*;

module fu_writeback_arbiter #(
  parameter int NUM_FU    = WB_NUM_FU,
  parameter int NUM_PORTS = WB_NUM_PORTS,
  parameter int PAYLOAD_W = WB_PAYLOAD_W,
  localparam int ID_W     = $clog2(NUM_FU)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_flush,
  input  logic [NUM_FU-1:0]             i_fu_valid,
  input  logic [NUM_FU-1:0]             i_fu_pair,
  input  logic [NUM_FU*PAYLOAD_W-1:0]   i_fu_payload0,
  input  logic [NUM_FU*PAYLOAD_W-1:0]   i_fu_payload1,
  output logic [NUM_FU-1:0]             o_fu_ready,
  input  logic                          i_commit_allowin,
  output logic [NUM_PORTS-1:0]          o_cm_valid,
  output logic [NUM_PORTS*PAYLOAD_W-1:0] o_cm_payload,
  output logic [NUM_PORTS*ID_W-1:0]     o_cm_fu_id
);

  logic [NUM_FU-1:0]                r_slot_v;
  logic [NUM_FU-1:0]                r_slot_pair;
  logic [PAYLOAD_W-1:0]             r_slot_p0 [NUM_FU];
  logic [PAYLOAD_W-1:0]             r_slot_p1 [NUM_FU];
  logic                             r_hold;
  logic [NUM_FU-1:0]                r_held;

  logic [NUM_FU-1:0]                w_arb_v;
  logic [NUM_PORTS-1:0][NUM_FU-1:0] w_port_sel;
  logic [NUM_FU-1:0]                w_granted;
  logic [NUM_FU-1:0]                w_consume;
  logic [NUM_FU-1:0]                w_accept;
  logic [NUM_FU-1:0]                w_ready;
  logic [ID_W-1:0]                  w_rr_ptr;
  logic [ID_W-1:0]                  w_last_id;
  logic [NUM_PORTS-1:0]             w_cm_valid;
  logic [NUM_PORTS*PAYLOAD_W-1:0]   w_cm_payload;
  logic [NUM_PORTS*ID_W-1:0]        w_cm_fu_id;
  logic                             w_consuming;

  // While commit stalls, only the slots already presented compete, so late
  // arrivals cannot reshuffle the buses commit is looking at.
  assign w_arb_v = r_slot_v & (r_hold ? r_held : {NUM_FU{1'b1}});

  wb_port_allocator #(.NUM_FU(NUM_FU), .NUM_PORTS(NUM_PORTS)) u_alloc (
    .i_slot_v    (w_arb_v),
    .i_slot_pair (r_slot_pair),
    .i_rr_ptr    (w_rr_ptr),
    .o_port_sel  (w_port_sel),
    .o_granted   (w_granted)
  );

  assign w_consuming = i_commit_allowin && !i_flush && !reset && (|w_granted);
  assign w_consume   = w_granted & {NUM_FU{w_consuming}};
  assign w_ready     = {NUM_FU{!reset && !i_flush}} & (~r_slot_v | w_consume);
  assign w_accept    = i_fu_valid & w_ready;
  assign o_fu_ready  = w_ready;

  always_comb begin
    w_cm_valid   = '0;
    w_cm_payload = '0;
    w_cm_fu_id   = '0;
    w_last_id    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_port_sel[p][i]) begin
          w_cm_valid[p] = 1'b1;
          w_cm_payload[p*PAYLOAD_W +: PAYLOAD_W] |=
            (p == 1 && r_slot_pair[i]) ? r_slot_p1[i] : r_slot_p0[i];
          w_cm_fu_id[p*ID_W +: ID_W] |= ID_W'(i);
          w_last_id = ID_W'(i);
        end
      end
    end
  end

  assign o_cm_valid   = reset ? '0 : w_cm_valid;
  assign o_cm_payload = reset ? '0 : w_cm_payload;
  assign o_cm_fu_id   = reset ? '0 : w_cm_fu_id;

  // NOTE: synchronous active-high reset clears only control state; payload
  // storage is qualified by r_slot_v and is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_slot_v <= '0;
      r_hold   <= 1'b0;
      r_held   <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_accept[i]) begin
          r_slot_v[i]    <= 1'b1;
          r_slot_pair[i] <= i_fu_pair[i];
        end else if (w_consume[i]) begin
          r_slot_v[i] <= 1'b0;
        end
      end
      r_hold <= (|w_granted) && !i_commit_allowin;
      r_held <= w_granted;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_accept[i]) begin
        r_slot_p0[i] <= i_fu_payload0[i*PAYLOAD_W +: PAYLOAD_W];
        r_slot_p1[i] <= i_fu_payload1[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

`ifdef WB_ARB_RR_EN
  logic [ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_consuming) begin
      r_rr_ptr <= (w_last_id == ID_W'(NUM_FU - 1)) ? '0 : w_last_id + 1'b1;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = '0;
`endif

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Directed bench for fu_writeback_arbiter; expectations follow WB_ARB_RR_EN
// in the saturation scenario and are fixed-priority everywhere else.
module tb_fu_writeback_arbiter;

  localparam int NF = 6;
  localparam int NP = 2;
  localparam int W  = 128;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [NF-1:0]     fu_valid;
  logic [NF-1:0]     fu_pair;
  logic [NF*W-1:0]   fu_payload0;
  logic [NF*W-1:0]   fu_payload1;
  logic [NF-1:0]     fu_ready;
  logic              commit_allowin;
  logic [NP-1:0]     cm_valid;
  logic [NP*W-1:0]   cm_payload;
  logic [NP*IW-1:0]  cm_fu_id;

  int n_checks = 0;
  int n_fail   = 0;

  fu_writeback_arbiter #(.NUM_FU(NF), .NUM_PORTS(NP), .PAYLOAD_W(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_flush          (flush),
    .i_fu_valid       (fu_valid),
    .i_fu_pair        (fu_pair),
    .i_fu_payload0    (fu_payload0),
    .i_fu_payload1    (fu_payload1),
    .o_fu_ready       (fu_ready),
    .i_commit_allowin (commit_allowin),
    .o_cm_valid       (cm_valid),
    .o_cm_payload     (cm_payload),
    .o_cm_fu_id       (cm_fu_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving time for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fu();
    fu_valid    = '0;
    fu_pair     = '0;
    fu_payload0 = '0;
    fu_payload1 = '0;
  endtask

  task automatic set_fu(input int i, input logic pair, input logic [W-1:0] p0, input logic [W-1:0] p1);
    fu_valid[i]             = 1'b1;
    fu_pair[i]              = pair;
    fu_payload0[i*W +: W]   = p0;
    fu_payload1[i*W +: W]   = p1;
  endtask

  function automatic logic [W-1:0] pl(input int p);
    return cm_payload[p*W +: W];
  endfunction

  function automatic logic [W-1:0] id(input int p);
    return W'(cm_fu_id[p*IW +: IW]);
  endfunction

  task automatic settle_check_cm(input string tag, input logic [NP-1:0] v,
                                 input int id0, input int id1);
    #1;
    check({tag, "_valid"}, W'(cm_valid), W'(v));
    check({tag, "_id0"}, id(0), W'(id0));
    check({tag, "_id1"}, id(1), W'(id1));
  endtask

  int exp_id0 [4];
  int exp_id1 [4];
  logic [NF-1:0] exp_rdy [4];

  initial begin
    reset = 1'b1; flush = 1'b0; commit_allowin = 1'b1;
    clr_fu();

    // Reset state
    tick(); tick();
    check("rst_cm_valid", W'(cm_valid), '0);
    check("rst_fu_ready", W'(fu_ready), '0);
    check("rst_payload", W'(cm_payload), '0);
    reset = 1'b0;
    #1;
    check("idle_ready", W'(fu_ready), W'(6'h3F));
    check("idle_valid", W'(cm_valid), '0);

    // Single accept and drain
    set_fu(2, 1'b0, 128'hA5, 128'h0);
    tick(); clr_fu();
    settle_check_cm("single", 2'b01, 2, 0);
    check("single_pl0", pl(0), 128'hA5);
    check("single_pl1", pl(1), '0);
    tick();
    check("single_drained", W'(cm_valid), '0);

    // Pair waits behind a single on port 0, then goes out whole
    set_fu(0, 1'b0, 128'h33, 128'h0);
    set_fu(3, 1'b1, 128'h11, 128'h22);
    tick(); clr_fu();
    settle_check_cm("pair_wait", 2'b01, 0, 0);
    check("pair_wait_pl0", pl(0), 128'h33);
    check("pair_wait_ready", W'(fu_ready), W'(6'b110111));
    tick();
    settle_check_cm("pair_go", 2'b11, 3, 3);
    check("pair_go_pl0", pl(0), 128'h11);
    check("pair_go_pl1", pl(1), 128'h22);
    tick();
    check("pair_drained", W'(cm_valid), '0);

    // Waiting pair does not block a lower-priority single
    set_fu(0, 1'b0, 128'h40, 128'h0);
    set_fu(3, 1'b1, 128'h41, 128'h42);
    set_fu(5, 1'b0, 128'h45, 128'h0);
    tick(); clr_fu();
    settle_check_cm("bypass", 2'b11, 0, 5);
    check("bypass_pl1", pl(1), 128'h45);
    tick();
    settle_check_cm("bypass_pair", 2'b11, 3, 3);
    check("bypass_pair_pl1", pl(1), 128'h42);
    tick();

    // Backpressure with slots 1,4 full; a late FU0 arrival must not disturb the grants
    set_fu(1, 1'b0, 128'h51, 128'h0);
    set_fu(4, 1'b0, 128'h54, 128'h0);
    tick(); clr_fu();
    commit_allowin = 1'b0;
    set_fu(0, 1'b0, 128'h50, 128'h0);
    for (int c = 0; c < 3; c++) begin
      settle_check_cm($sformatf("bp%0d", c), 2'b11, 1, 4);
      check($sformatf("bp%0d_pl0", c), pl(0), 128'h51);
      check($sformatf("bp%0d_rdy14", c), W'({fu_ready[4], fu_ready[1]}), '0);
      tick(); clr_fu();
    end
    commit_allowin = 1'b1;
    settle_check_cm("bp_release", 2'b11, 1, 4);
    tick();
    settle_check_cm("bp_after", 2'b01, 0, 0);
    check("bp_after_pl0", pl(0), 128'h50);
    tick();
    check("bp_drained", W'(cm_valid), '0);

    // Flush with slots 0,1,5 full and FU2 offering
    commit_allowin = 1'b0;
    set_fu(0, 1'b0, 128'h60, 128'h0);
    set_fu(1, 1'b0, 128'h61, 128'h0);
    set_fu(5, 1'b0, 128'h65, 128'h0);
    tick(); clr_fu();
    flush = 1'b1; commit_allowin = 1'b1;
    set_fu(2, 1'b0, 128'h62, 128'h0);
    #1;
    check("flush_ready", W'(fu_ready), '0);
    tick(); clr_fu(); flush = 1'b0;
    #1;
    check("post_flush_valid", W'(cm_valid), '0);
    check("post_flush_ready", W'(fu_ready), W'(6'h3F));

    // Saturation: all six FUs offer continuously
`ifdef WB_ARB_RR_EN
    exp_id0 = '{0, 2, 4, 0}; exp_id1 = '{1, 3, 5, 1};
    exp_rdy = '{6'b000011, 6'b001100, 6'b110000, 6'b000011};
`else
    exp_id0 = '{0, 0, 0, 0}; exp_id1 = '{1, 1, 1, 1};
    exp_rdy = '{6'b000011, 6'b000011, 6'b000011, 6'b000011};
`endif
    for (int i = 0; i < NF; i++) set_fu(i, 1'b0, W'(8'h70 + i), 128'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      settle_check_cm($sformatf("sat%0d", c), 2'b11, exp_id0[c], exp_id1[c]);
      check($sformatf("sat%0d_rdy", c), W'(fu_ready), W'(exp_rdy[c]));
      tick();
    end

    // Reset mid-stream with slots full and every FU still offering
    reset = 1'b1;
    #1;
    check("rst_mid_valid", W'(cm_valid), '0);
    check("rst_mid_ready", W'(fu_ready), '0);
    tick();
    check("rst_mid_valid2", W'(cm_valid), '0);
    reset = 1'b0; clr_fu();
    #1;
    check("rst_rel_valid", W'(cm_valid), '0);
    check("rst_rel_ready", W'(fu_ready), W'(6'h3F));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
